// File: rtl/branch_predict.sv
// Branch predictor and EX-stage branch resolver.
// A table of 2-bit saturating counters (BHT) predicts fetch-stage branches;
// the EX stage resolves branch/jump outcomes, trains the table, and reports
// a registered resolution with the corrected next-fetch PC.
// Optional build macro: BRANCH_PREDICT_BYPASS_EN -- when defined, a fetch
// lookup that hits the counter being trained this cycle sees the trained
// value instead of the stale one.
module branch_predict #(
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned PC_W      = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [7:0]      ex_type,
    input  logic [PC_W-1:0] ex_opa,
    input  logic [PC_W-1:0] ex_opb,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic            flush,
    output logic            res_valid,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic [PC_W-1:0] res_redirect_pc,
    output logic [31:0]     perf_miss
);

    localparam int unsigned IDX_W  = $clog2(BHT_DEPTH);
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned PERF_W = 32;

    localparam logic [CNT_W-1:0] CNT_RESET = 2'b01;
    localparam logic [CNT_W-1:0] CNT_MAX   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MIN   = 2'b00;

    logic [CNT_W-1:0] bht [BHT_DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             accept;
    logic             type_onehot;
    logic             is_cond;
    logic             bht_update;
    logic             act_taken;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] nxt_cnt;
    logic             opa_neg;
    logic             opa_zero;
    logic             ops_eq;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Only the word-index bits of the fetch PC address the table.
    assign unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

    // Decode the EX instruction and compute its actual outcome and redirect.
    always_comb begin
        accept      = ex_valid & ~flush;
        type_onehot = (ex_type != 8'h00) && ((ex_type & (ex_type - 8'h01)) == 8'h00);
        is_cond     = type_onehot && (ex_type[5:0] != 6'h00);
        bht_update  = accept & is_cond;

        opa_neg  = ex_opa[PC_W-1];
        opa_zero = (ex_opa == '0);
        ops_eq   = (ex_opa == ex_opb);

        // With a one-hot type, AND-OR selects the single applicable condition.
        act_taken = 1'b0;
        if (type_onehot) begin
            act_taken = |(ex_type & {1'b1, 1'b1, opa_neg, opa_neg | opa_zero,
                                     ~opa_neg & ~opa_zero, ~opa_neg, ~ops_eq, ops_eq});
        end

        mispredict = act_taken ^ ex_pred_taken;

        if (!act_taken) begin
            redirect_pc = ex_pc + PC_W'(8);
        end else if (ex_type[7]) begin
            redirect_pc = ex_opa;
        end else begin
            redirect_pc = ex_target;
        end
    end

    // Saturating counter step for the entry being trained.
    always_comb begin
        cur_cnt = bht[ex_idx];
        nxt_cnt = cur_cnt;
        if (act_taken) begin
            if (cur_cnt != CNT_MAX) begin
                nxt_cnt = cur_cnt + CNT_W'(1);
            end
        end else begin
            if (cur_cnt != CNT_MIN) begin
                nxt_cnt = cur_cnt - CNT_W'(1);
            end
        end
    end

    // Fetch-side prediction from the counter MSB.
    always_comb begin
`ifdef BRANCH_PREDICT_BYPASS_EN
        if (bht_update && (if_idx == ex_idx)) begin
            if_pred_taken = nxt_cnt[1];
        end else begin
            if_pred_taken = bht[if_idx][1];
        end
`else
        if_pred_taken = bht[if_idx][1];
`endif
    end

    // Counter table: reset to weakly not-taken, trained by conditional branches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CNT_RESET;
            end
        end else if (bht_update) begin
            bht[ex_idx] <= nxt_cnt;
        end
    end

    // Registered resolution; payload holds its value across idle cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            res_valid       <= 1'b0;
            res_taken       <= 1'b0;
            res_mispredict  <= 1'b0;
            res_redirect_pc <= '0;
        end else begin
            res_valid <= accept;
            if (accept) begin
                res_taken       <= act_taken;
                res_mispredict  <= mispredict;
                res_redirect_pc <= redirect_pc;
            end
        end
    end

    // Saturating mispredict counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_miss <= '0;
        end else if (accept && mispredict && (perf_miss != '1)) begin
            perf_miss <= perf_miss + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict.sv
// Directed testbench for branch_predict with hand-computed expectations.
// Build with BRANCH_PREDICT_BYPASS_EN defined to check the bypass variant.
module tb_branch_predict;

    localparam logic [7:0] T_BEQ  = 8'h01;
    localparam logic [7:0] T_BNE  = 8'h02;
    localparam logic [7:0] T_BGEZ = 8'h04;
    localparam logic [7:0] T_BGTZ = 8'h08;
    localparam logic [7:0] T_BLEZ = 8'h10;
    localparam logic [7:0] T_BLTZ = 8'h20;
    localparam logic [7:0] T_J    = 8'h40;
    localparam logic [7:0] T_JR   = 8'h80;

`ifdef BRANCH_PREDICT_BYPASS_EN
    localparam logic BYP_EXP = 1'b1;
`else
    localparam logic BYP_EXP = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [7:0]  ex_type;
    logic [31:0] ex_opa;
    logic [31:0] ex_opb;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        flush;
    logic        res_valid;
    logic        res_taken;
    logic        res_mispredict;
    logic [31:0] res_redirect_pc;
    logic [31:0] perf_miss;

    int n_vec  = 0;
    int n_miss = 0;

    branch_predict #(.BHT_DEPTH(64), .PC_W(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .if_pc           (if_pc),
        .if_pred_taken   (if_pred_taken),
        .ex_valid        (ex_valid),
        .ex_type         (ex_type),
        .ex_opa          (ex_opa),
        .ex_opb          (ex_opb),
        .ex_pc           (ex_pc),
        .ex_target       (ex_target),
        .ex_pred_taken   (ex_pred_taken),
        .flush           (flush),
        .res_valid       (res_valid),
        .res_taken       (res_taken),
        .res_mispredict  (res_mispredict),
        .res_redirect_pc (res_redirect_pc),
        .perf_miss       (perf_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        ex_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle();
        ex_type = 8'h00; ex_opa = '0; ex_opb = '0; ex_pc = '0; ex_target = '0;
        ex_pred_taken = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    // Present one EX instruction across a rising edge; sample 1 time unit after.
    task automatic issue(input logic [7:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic fl);
        ex_valid = 1'b1; ex_type = t; ex_opa = a; ex_opb = b;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; flush = fl;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        if_pc = 32'h1000;
        #1;
        n_vec++; if (if_pred_taken !== 1'b0) begin n_miss++; $display("FAIL reset_pred got %0b exp 0", if_pred_taken); end
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL reset_valid got %0b exp 0", res_valid); end
        n_vec++; if (perf_miss !== 32'd0) begin n_miss++; $display("FAIL reset_perf got %0d exp 0", perf_miss); end
        n_vec++; if (res_redirect_pc !== 32'd0) begin n_miss++; $display("FAIL reset_redirect got %h exp 0", res_redirect_pc); end
        n_vec++; if ({res_taken, res_mispredict} !== 2'b00) begin n_miss++; $display("FAIL reset_taken_mp got %b exp 00", {res_taken, res_mispredict}); end
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_beq_train();
        logic [2:0] exp_mp [3] = '{1'b1, 1'b1, 1'b0};
        logic       preds  [3] = '{1'b0, 1'b0, 1'b1};
        int         exp_pm [3] = '{1, 2, 2};
        do_reset();
        if_pc = 32'h1000;
        for (int i = 0; i < 3; i++) begin
            issue(T_BEQ, 32'd5, 32'd5, 32'h1000, 32'h1040, preds[i], 1'b0);
            n_vec++; if (res_valid !== 1'b1 || res_taken !== 1'b1) begin n_miss++; $display("FAIL beq%0d valid/taken got %b%b exp 11", i, res_valid, res_taken); end
            n_vec++; if (res_mispredict !== exp_mp[i][0]) begin n_miss++; $display("FAIL beq%0d mispredict got %0b exp %0b", i, res_mispredict, exp_mp[i][0]); end
            n_vec++; if (res_redirect_pc !== 32'h1040) begin n_miss++; $display("FAIL beq%0d redirect got %h exp 00001040", i, res_redirect_pc); end
            n_vec++; if (if_pred_taken !== 1'b1) begin n_miss++; $display("FAIL beq%0d pred got %0b exp 1", i, if_pred_taken); end
            n_vec++; if (perf_miss !== 32'(exp_pm[i])) begin n_miss++; $display("FAIL beq%0d perf got %0d exp %0d", i, perf_miss, exp_pm[i]); end
        end
        // Counter saturated at 11: one not-taken drops it to 10, still predicting taken.
        issue(T_BEQ, 32'd1, 32'd2, 32'h1000, 32'h1040, 1'b1, 1'b0);
        n_vec++; if (if_pred_taken !== 1'b1) begin n_miss++; $display("FAIL beq_sat pred got %0b exp 1", if_pred_taken); end
        n_vec++; if (res_redirect_pc !== 32'h1008) begin n_miss++; $display("FAIL beq_nt redirect got %h exp 00001008", res_redirect_pc); end
        n_vec++; if (res_taken !== 1'b0 || res_mispredict !== 1'b1 || perf_miss !== 32'd3) begin n_miss++; $display("FAIL beq_nt taken/mp/perf got %b%b/%0d exp 01/3", res_taken, res_mispredict, perf_miss); end
        idle();
    endtask

    task automatic test_compare();
        logic [7:0]  tt [11] = '{T_BLTZ, T_BGTZ, T_BLEZ, T_BGEZ, T_BGEZ, T_BNE, T_BNE, T_BLEZ, T_BGTZ, T_J, T_JR};
        logic [31:0] ta [11] = '{32'h8000_0000, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'd1, 32'd7, 32'd1, 32'h7FFF_FFFF, 32'h0, 32'h0000_1234};
        logic [31:0] tb [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'd2, 32'd7, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] tp [11] = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'hFFFF_FFFC, 32'h2000, 32'h2000, 32'h2000, 32'h2000};
        logic        te [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] tr [11] = '{32'h5000, 32'h2008, 32'h5000, 32'h2008, 32'h5000, 32'h5000, 32'h0000_0004, 32'h2008, 32'h5000, 32'h5000, 32'h0000_1234};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            issue(tt[i], ta[i], tb[i], tp[i], 32'h5000, 1'b0, 1'b0);
            n_vec++; if (res_taken !== te[i] || res_mispredict !== te[i]) begin n_miss++; $display("FAIL cmp%0d taken/mp got %b%b exp %b%b", i, res_taken, res_mispredict, te[i], te[i]); end
            n_vec++; if (res_redirect_pc !== tr[i]) begin n_miss++; $display("FAIL cmp%0d redirect got %h exp %h", i, res_redirect_pc, tr[i]); end
        end
        idle();
    endtask

    task automatic test_jr();
        do_reset();
        if_pc = 32'h1000;
        issue(T_JR, 32'h0040_0100, 32'h0, 32'h1000, 32'h9999_0000, 1'b0, 1'b0);
        n_vec++; if (res_taken !== 1'b1 || res_mispredict !== 1'b1) begin n_miss++; $display("FAIL jr taken/mp got %b%b exp 11", res_taken, res_mispredict); end
        n_vec++; if (res_redirect_pc !== 32'h0040_0100) begin n_miss++; $display("FAIL jr redirect got %h exp 00400100", res_redirect_pc); end
        n_vec++; if (if_pred_taken !== 1'b0) begin n_miss++; $display("FAIL jr bht_touched pred got %0b exp 0", if_pred_taken); end
        n_vec++; if (perf_miss !== 32'd1) begin n_miss++; $display("FAIL jr perf got %0d exp 1", perf_miss); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        if_pc = 32'h1000;
        issue(T_BEQ, 32'd5, 32'd5, 32'h1000, 32'h1040, 1'b0, 1'b1);
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL flush valid got %0b exp 0", res_valid); end
        n_vec++; if (perf_miss !== 32'd0) begin n_miss++; $display("FAIL flush perf got %0d exp 0", perf_miss); end
        n_vec++; if (if_pred_taken !== 1'b0) begin n_miss++; $display("FAIL flush bht pred got %0b exp 0", if_pred_taken); end
        n_vec++; if (res_redirect_pc !== 32'd0) begin n_miss++; $display("FAIL flush redirect got %h exp 0", res_redirect_pc); end
        idle();
    endtask

    task automatic test_back_to_back();
        // Continues from the flushed state: counter 01, perf 0.
        issue(T_BEQ, 32'd5, 32'd5, 32'h1000, 32'h1040, 1'b0, 1'b0);
        issue(T_BNE, 32'd5, 32'd5, 32'h1000, 32'h1040, 1'b1, 1'b0);
        n_vec++; if (res_valid !== 1'b1 || res_redirect_pc !== 32'h1008) begin n_miss++; $display("FAIL b2b second valid/redirect got %0b/%h exp 1/00001008", res_valid, res_redirect_pc); end
        n_vec++; if (perf_miss !== 32'd2) begin n_miss++; $display("FAIL b2b perf got %0d exp 2", perf_miss); end
        idle();
        @(posedge clk); #1;
        n_vec++; if (res_valid !== 1'b0) begin n_miss++; $display("FAIL idle valid got %0b exp 0", res_valid); end
        n_vec++; if (res_redirect_pc !== 32'h1008 || res_taken !== 1'b0 || res_mispredict !== 1'b1) begin n_miss++; $display("FAIL idle hold got %h/%b%b exp 00001008/01", res_redirect_pc, res_taken, res_mispredict); end
    endtask

    task automatic test_nonhot();
        do_reset();
        if_pc = 32'h1000;
        issue(8'h03, 32'd5, 32'd5, 32'h1000, 32'h1040, 1'b1, 1'b0);
        n_vec++; if (res_valid !== 1'b1 || res_taken !== 1'b0 || res_mispredict !== 1'b1) begin n_miss++; $display("FAIL nonhot v/t/mp got %b%b%b exp 101", res_valid, res_taken, res_mispredict); end
        n_vec++; if (res_redirect_pc !== 32'h1008) begin n_miss++; $display("FAIL nonhot redirect got %h exp 00001008", res_redirect_pc); end
        issue(8'h00, 32'd5, 32'd5, 32'h1000, 32'h1040, 1'b0, 1'b0);
        n_vec++; if (res_valid !== 1'b1 || res_mispredict !== 1'b0 || perf_miss !== 32'd1) begin n_miss++; $display("FAIL zerotype v/mp/perf got %b%b/%0d exp 10/1", res_valid, res_mispredict, perf_miss); end
        n_vec++; if (if_pred_taken !== 1'b0) begin n_miss++; $display("FAIL nonhot bht pred got %0b exp 0", if_pred_taken); end
        idle();
    endtask

    task automatic test_bypass();
        do_reset();
        if_pc = 32'h3000;
        ex_valid = 1'b1; ex_type = T_BEQ; ex_opa = 32'd9; ex_opb = 32'd9;
        ex_pc = 32'h3000; ex_target = 32'h3100; ex_pred_taken = 1'b0; flush = 1'b0;
        #1;
        n_vec++; if (if_pred_taken !== BYP_EXP) begin n_miss++; $display("FAIL bypass same_cycle pred got %0b exp %0b", if_pred_taken, BYP_EXP); end
        @(posedge clk); #1;
        idle();
        n_vec++; if (if_pred_taken !== 1'b1) begin n_miss++; $display("FAIL bypass after pred got %0b exp 1", if_pred_taken); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_pc = 32'h1000;
        issue(T_BEQ, 32'd5, 32'd5, 32'h1000, 32'h1040, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        n_vec++; if (res_valid !== 1'b0 || res_taken !== 1'b0 || res_mispredict !== 1'b0) begin n_miss++; $display("FAIL midrst v/t/mp got %b%b%b exp 000", res_valid, res_taken, res_mispredict); end
        n_vec++; if (perf_miss !== 32'd0 || res_redirect_pc !== 32'd0) begin n_miss++; $display("FAIL midrst perf/redirect got %0d/%h exp 0/0", perf_miss, res_redirect_pc); end
        n_vec++; if (if_pred_taken !== 1'b0) begin n_miss++; $display("FAIL midrst pred got %0b exp 0", if_pred_taken); end
        @(posedge clk); #1;
        resetn = 1'b1;
        issue(T_BNE, 32'd1, 32'd2, 32'h1000, 32'h1040, 1'b1, 1'b0);
        n_vec++; if (res_valid !== 1'b1 || res_redirect_pc !== 32'h1040 || res_mispredict !== 1'b0) begin n_miss++; $display("FAIL first_accept v/redirect/mp got %0b/%h/%0b exp 1/00001040/0", res_valid, res_redirect_pc, res_mispredict); end
        idle();
    endtask

    initial begin
        resetn = 1'b0;
        if_pc = '0;
        ex_type = 8'h00; ex_opa = '0; ex_opb = '0; ex_pc = '0; ex_target = '0;
        ex_pred_taken = 1'b0;
        idle();
        test_reset();
        test_beq_train();
        test_compare();
        test_jr();
        test_flush();
        test_back_to_back();
        test_nonhot();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
